// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial WIDTH-bit add/subtract built around a single 4-bit ripple slice.
// WIDTH must be a multiple of 4 and at least 4.

module adder4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);
  logic [4:0] carry;

  assign carry[0] = c_i;

  for (genvar gi = 0; gi < 4; gi++) begin : g_bit
    assign s_o[gi]      = a_i[gi] ^ b_i[gi] ^ carry[gi];
    assign carry[gi+1]  = (a_i[gi] & b_i[gi]) | (carry[gi] & (a_i[gi] ^ b_i[gi]));
  end

  assign c_o = carry[4];
endmodule

module nibble_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z,
  output logic             cout,
  output logic             ovf
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [3:0] opa_nib [NIBBLES];
  logic [3:0] opb_nib [NIBBLES];
  logic [3:0] nib_a, nib_b, nib_s;
  logic       nib_c;
  logic       last_nib;

  for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
    assign opa_nib[gi] = opa_q[4*gi +: 4];
    assign opb_nib[gi] = opb_q[4*gi +: 4];
  end

  assign nib_a    = opa_nib[cnt_q];
  assign nib_b    = opb_nib[cnt_q];
  assign last_nib = (cnt_q == CW'(NIBBLES - 1));

  adder4 u_slice (
    .a_i (nib_a),
    .b_i (nib_b),
    .c_i (carry_q),
    .s_o (nib_s),
    .c_o (nib_c)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    carry_d = carry_q;
    z_d     = z_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          // Subtraction is a + ~b + 1, so the slice never needs to know the op.
          opa_d   = a;
          opb_d   = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        for (int i = 0; i < NIBBLES; i++) begin
          if (cnt_q == CW'(i)) z_d[4*i +: 4] = nib_s;
        end
        carry_d = nib_c;
        cnt_d   = last_nib ? '0 : cnt_q + 1'b1;
        if (last_nib) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cout_d  = nib_c;
          ovf_d   = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) && (nib_s[3] != opa_q[WIDTH-1]);
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      carry_q <= 1'b0;
      z_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      carry_q <= carry_d;
      z_q     <= z_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign z    = z_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed plus random bench for nibble_serial_add_ctrl (WIDTH=16) with an
// arithmetic reference model.

module tb_nibble_serial_add_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        sub = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        busy, done, cout, ovf;
  logic [15:0] z;

  int checks = 0;
  int fails  = 0;

  nibble_serial_add_ctrl #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .z     (z),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the whole operands.
  function automatic logic [17:0] model(input logic [15:0] av, input logic [15:0] bv,
                                        input logic ci, input logic s);
    int unsigned sum;
    logic [15:0] zz;
    logic        co, ov;
    if (!s) begin
      sum = 32'(av) + 32'(bv) + 32'(ci);
      zz  = sum[15:0];
      co  = sum[16];
      ov  = (av[15] == bv[15]) && (zz[15] != av[15]);
    end else begin
      zz = av - bv;
      co = (av >= bv);
      ov = (av[15] != bv[15]) && (zz[15] != av[15]);
    end
    return {co, ov, zz};
  endfunction

  task automatic drive(input logic [15:0] av, input logic [15:0] bv, input logic ci, input logic s);
    start = 1'b1;
    a     = av;
    b     = bv;
    cin   = ci;
    sub   = s;
  endtask

  // Entered at the negedge of the cycle in which start is presented.
  task automatic run_op(input string tag, input logic [15:0] ez, input logic ec, input logic eo,
                        input bit noise, input bit chain,
                        input logic [15:0] na, input logic [15:0] nb, input logic nci, input logic ns);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) begin
        start = 1'b0;
        a     = 16'($urandom);
        b     = 16'($urandom);
        cin   = 1'($urandom);
        sub   = 1'($urandom);
      end
      if (noise && i == 2) start = 1'b1;
      if (noise && i == 3) start = 1'b0;
      chk($sformatf("%s busy c%0d", tag, i), 32'(busy), 32'd1);
      chk($sformatf("%s done c%0d", tag, i), 32'(done), 32'd0);
    end
    @(negedge clk);
    chk({tag, " done c5"}, 32'(done), 32'd1);
    chk({tag, " busy c5"}, 32'(busy), 32'd0);
    chk({tag, " z"}, 32'(z), 32'(ez));
    chk({tag, " cout"}, 32'(cout), 32'(ec));
    chk({tag, " ovf"}, 32'(ovf), 32'(eo));
    $display("op %s: z=%h cout=%0d ovf=%0d", tag, z, cout, ovf);
    if (chain) begin
      drive(na, nb, nci, ns);
    end else begin
      @(negedge clk);
      chk({tag, " done drop"}, 32'(done), 32'd0);
      chk({tag, " z held"}, 32'(z), 32'(ez));
      chk({tag, " cout held"}, 32'(cout), 32'(ec));
      chk({tag, " ovf held"}, 32'(ovf), 32'(eo));
    end
  endtask

  initial begin
    logic [17:0] m;
    logic [15:0] ra, rb;
    logic        rc, rs;

    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst z", 32'(z), 32'd0);
    chk("rst cout", 32'(cout), 32'd0);
    chk("rst ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    drive(16'h1234, 16'h0FED, 1'b0, 1'b0);
    run_op("add", 16'h2221, 1'b0, 1'b0, 0, 1, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    run_op("b2b ovf add", 16'h8000, 1'b0, 1'b1, 0, 0, '0, '0, 1'b0, 1'b0);

    drive(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    run_op("ripple", 16'h0000, 1'b1, 1'b0, 0, 1, 16'hFFFF, 16'h0000, 1'b1, 1'b0);
    run_op("ripple cin", 16'h0000, 1'b1, 1'b0, 0, 0, '0, '0, 1'b0, 1'b0);

    drive(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
    run_op("start in run", 16'h1000, 1'b0, 1'b0, 1, 0, '0, '0, 1'b0, 1'b0);

    drive(16'h0005, 16'h0007, 1'b1, 1'b1);
    run_op("sub borrow", 16'hFFFE, 1'b0, 1'b0, 0, 0, '0, '0, 1'b0, 1'b0);

    drive(16'h8000, 16'h0001, 1'b0, 1'b1);
    run_op("sub ovf", 16'h7FFF, 1'b1, 1'b1, 0, 0, '0, '0, 1'b0, 1'b0);

    // Abort in the third RUN cycle, between clock edges.
    drive(16'h1234, 16'h1111, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort z", 32'(z), 32'd0);
    chk("abort cout", 32'(cout), 32'd0);
    chk("abort ovf", 32'(ovf), 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("abort hold done", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post abort done", 32'(done), 32'd0);
      chk("post abort busy", 32'(busy), 32'd0);
    end
    drive(16'h0001, 16'h0001, 1'b0, 1'b0);
    run_op("after reset", 16'h0002, 1'b0, 1'b0, 0, 0, '0, '0, 1'b0, 1'b0);

    for (int n = 0; n < 24; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      rs = 1'($urandom);
      m  = model(ra, rb, rc, rs);
      drive(ra, rb, rc, rs);
      run_op($sformatf("rnd%0d %h%s%h", n, ra, rs ? "-" : "+", rb),
             m[15:0], m[17], m[16], (n % 3) == 1, 0, '0, '0, 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
- Sequencer that performs a WIDTH-bit add or subtract by time-multiplexing one existing 4-bit ripple adder slice (Adder4), one nibble per clock, LSB nibble first.
- Holds operands, the inter-nibble carry register, the nibble counter and a start/busy/done handshake.
- Trades latency for area in wide-operand datapaths built from the 4-bit slice.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 4 and at least 4; NIBBLES = WIDTH/4 is derived internally.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE or DONE.
- sub  input  1  0 = a+b+cin, 1 = a-b (cin ignored).
- a  input  WIDTH  operand A; sampled when start is accepted.
- b  input  WIDTH  operand B; sampled when start is accepted.
- cin  input  1  carry-in for add; sampled when start is accepted.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result valid.
- z  output  WIDTH  sum or difference.
- cout  output  1  final carry-out; for sub, 1 = no borrow (a >= b unsigned).
- ovf  output  1  two's-complement overflow.

Behaviour:
- Reset: rst_n low forces IDLE immediately, regardless of clk. Reset values: busy=0, done=0, z=0, cout=0, ovf=0, counter=0, carry register=0.
- States:
  - IDLE: start=1 latches a into opA and b (or ~b when sub=1) into opB. Carry register loads cin when sub=0, or 1 when sub=1. Counter clears, state goes to RUN.
  - RUN: busy=1. Each cycle the Adder4 instance takes opA nibble[cnt], opB nibble[cnt] and the carry register. Its 4-bit sum is written to z nibble[cnt] and its cout goes into the carry register; cnt increments. When cnt = NIBBLES-1 the state goes to DONE on that edge.
  - DONE: done=1 for exactly one cycle, busy=0; cout = carry register. Then IDLE, or RUN if start=1 in this cycle (back-to-back accepted, same latching as IDLE).
- Latency: start accepted on edge 0, RUN for NIBBLES cycles, done high during the cycle after the final RUN edge. For WIDTH=16, done is high in cycle 5 relative to the start cycle.
- ovf = (opA[WIDTH-1] == opB[WIDTH-1]) && (z[WIDTH-1] != opA[WIDTH-1]), computed from the inverted opB when subtracting. Registered with done.
- z, cout, ovf:
  - Valid from the done cycle.
  - Held stable until the next accepted start.
  - z contents are unspecified during RUN; the bench must not check them.
- start while in RUN is ignored; no queueing, no error flag. Operand inputs may change freely after acceptance.
- Reset asserted mid-RUN aborts the operation: all outputs are back at reset values in the same cycle, and no done is emitted. After release the block accepts start normally.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan (WIDTH=16):
- Add: a=0x1234, b=0x0FED, cin=0, sub=0 -> z=0x2221, cout=0, ovf=0; done high exactly 5 cycles after the start cycle, busy high 4 cycles.
- Carry ripple across all nibbles: a=0xFFFF, b=0x0001, cin=0 -> z=0x0000, cout=1, ovf=0. Also a=0xFFFF, b=0x0000, cin=1 -> z=0x0000, cout=1.
- Signed overflow: a=0x7FFF, b=0x0001 add -> z=0x8000, cout=0, ovf=1. Sub a=0x8000, b=0x0001 -> z=0x7FFF, cout=1, ovf=1.
- Subtract with borrow: a=0x0005, b=0x0007, sub=1, cin=1 (must be ignored) -> z=0xFFFE, cout=0, ovf=0.
- Handshake: start pulsed during RUN with different operands -> ignored, first result unchanged. start held high in the done cycle -> second operation runs back-to-back with done 5 cycles later and the correct second result.
- Reset mid-operation: drop rst_n during the third RUN cycle, between clock edges -> busy, done, z, cout, ovf go to 0 immediately with no done pulse. After release, a=0x0001, b=0x0001 -> z=0x0002.
